// File: rtl/cw_sequencer.sv
// cw_sequencer: microprogram store that issues control words to the datapath over a valid/ready handshake.
// Optional per-entry even parity check is enabled by defining CW_PARITY_EN.
module cw_sequencer #(
   parameter int CW_WIDTH = 55,
   parameter int DEPTH    = 64,
   parameter int ADDR_W   = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_en,
   input  logic [ADDR_W-1:0]   load_addr,
   input  logic [CW_WIDTH-1:0] load_data,
   input  logic                start,
   input  logic                stop,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic [ADDR_W-1:0]   end_addr,
   output logic [CW_WIDTH-1:0] cw_out,
   output logic                cw_valid,
   input  logic                cw_ready,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   pc,
   output logic                parity_err
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [0:0]          state;
   logic [CW_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]   end_q;
   logic [ADDR_W-1:0]   pc_inc;
   logic [ADDR_W-1:0]   rd_addr;
   logic [CW_WIDTH-1:0] rd_word;
   logic                accept;
   logic                wr_en;
   logic                start_go;
   logic                issue_next;
   logic                issue_load;

   assign accept     = cw_valid & cw_ready;
   assign wr_en      = rst_n & (state == S_IDLE) & load_en;
   assign start_go   = (state == S_IDLE) & start & ~load_en;
   assign issue_next = (state == S_RUN) & ~stop & accept & (pc != end_q);
   assign issue_load = start_go | issue_next;
   assign pc_inc     = (pc == LAST_ADDR) ? '0 : pc + 1'b1;
   // In IDLE the read port looks ahead to start_addr so the first word is ready one cycle after start.
   assign rd_addr    = (state == S_IDLE) ? start_addr : pc_inc;
   assign rd_word    = mem[rd_addr];
   assign busy       = (state == S_RUN);

   // Microprogram storage is deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cw_out   <= '0;
         cw_valid <= 1'b0;
         done     <= 1'b0;
         pc       <= '0;
         end_q    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_go) begin
                  end_q    <= end_addr;
                  pc       <= start_addr;
                  cw_out   <= rd_word;
                  cw_valid <= 1'b1;
                  state    <= S_RUN;
               end
            end
            default: begin
               // stop wins over a same-cycle accept: the current word is dropped without done.
               if (stop) begin
                  cw_out   <= '0;
                  cw_valid <= 1'b0;
                  state    <= S_IDLE;
               end else if (accept) begin
                  if (pc == end_q) begin
                     cw_out   <= '0;
                     cw_valid <= 1'b0;
                     done     <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     pc     <= pc_inc;
                     cw_out <= rd_word;
                  end
               end
            end
         endcase
      end
   end

`ifdef CW_PARITY_EN
   logic par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         par_mem[load_addr] <= ^load_data;
      end
   end

   // A mismatching word is still issued; the error only latches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
      end else if (issue_load && ((^rd_word) != par_mem[rd_addr])) begin
         parity_err <= 1'b1;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cw_sequencer.sv
// tb_cw_sequencer: directed and randomized sequences checked against a queue-based model of the issue order.
module tb_cw_sequencer;
   localparam int CW_WIDTH = 55;
   localparam int DEPTH    = 64;
   localparam int ADDR_W   = 6;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                load_en = 1'b0;
   logic [ADDR_W-1:0]   load_addr = '0;
   logic [CW_WIDTH-1:0] load_data = '0;
   logic                start = 1'b0;
   logic                stop = 1'b0;
   logic [ADDR_W-1:0]   start_addr = '0;
   logic [ADDR_W-1:0]   end_addr = '0;
   logic [CW_WIDTH-1:0] cw_out;
   logic                cw_valid;
   logic                cw_ready = 1'b0;
   logic                busy;
   logic                done;
   logic [ADDR_W-1:0]   pc;
   logic                parity_err;

   int total = 0;
   int bad   = 0;
   logic [CW_WIDTH-1:0] mem_m [DEPTH];
   logic perr_m = 1'b0;
   int   corrupt_addr = -1;

   always #5 clk = ~clk;

   cw_sequencer #(.CW_WIDTH(CW_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(start), .stop(stop), .start_addr(start_addr), .end_addr(end_addr),
      .cw_out(cw_out), .cw_valid(cw_valid), .cw_ready(cw_ready), .busy(busy), .done(done),
      .pc(pc), .parity_err(parity_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW_WIDTH-1:0] rnd_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[CW_WIDTH-1:0];
   endfunction

   task automatic load(input int a, input logic [CW_WIDTH-1:0] d);
      load_en   = 1'b1;
      load_addr = ADDR_W'(a);
      load_data = d;
      step();
      load_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic chk_idle(input string tag, input logic exp_done);
      chk({tag, "_valid"}, 64'(cw_valid), 64'(0));
      chk({tag, "_out"}, 64'(cw_out), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(exp_done));
   endtask

   // Expected order is the address list start..end walked modulo DEPTH; each accept pops one entry.
   task automatic run_seq(input int sa, input int ea, input int pct, input int stop_idx,
                          input bit inject, input int hold_first);
      int  list[$];
      int  a;
      int  idx;
      int  guard;
      bit  rdy;
      bit  stp;
      list.push_back(sa);
      a = sa;
      while (a != ea) begin
         a = (a + 1) % DEPTH;
         list.push_back(a);
      end
      idx = 0;
      guard = 0;
      start_addr = ADDR_W'(sa);
      end_addr   = ADDR_W'(ea);
      start = 1'b1;
      step();
      start = 1'b0;
      while (idx < list.size()) begin
         if (list[idx] == corrupt_addr) perr_m = 1'b1;
         chk("run_valid", 64'(cw_valid), 64'(1));
         chk("run_word", 64'(cw_out), 64'(mem_m[list[idx]]));
         chk("run_pc", 64'(pc), 64'(list[idx]));
         chk("run_busy", 64'(busy), 64'(1));
         chk("run_done_low", 64'(done), 64'(0));
         chk("run_parity", 64'(parity_err), 64'(perr_m));
         rdy = (guard < hold_first) ? 1'b0 : ($urandom_range(99) < pct);
         stp = (idx == stop_idx) && rdy;
         cw_ready = rdy;
         stop = stp;
         if (inject && guard == 0) begin
            load_en    = 1'b1;
            load_addr  = ADDR_W'(1);
            load_data  = rnd_word();
            start      = 1'b1;
            start_addr = ADDR_W'((sa + 5) % DEPTH);
         end
         step();
         cw_ready = 1'b0;
         stop     = 1'b0;
         load_en  = 1'b0;
         start    = 1'b0;
         guard++;
         if (stp) begin
            chk_idle("stop", 1'b0);
            return;
         end
         if (rdy) idx++;
         if (guard > 4000) begin
            chk("timeout", 64'(guard), 64'(0));
            return;
         end
      end
      chk_idle("end", 1'b1);
      step();
      chk("done_clear", 64'(done), 64'(0));
   endtask

   initial begin
      int sa;
      int ea;
      int si;
      logic [CW_WIDTH-1:0] d;

      rst_n = 1'b0;
      step();
      step();
      chk_idle("reset", 1'b0);
      chk("reset_pc", 64'(pc), 64'(0));
      chk("reset_parity", 64'(parity_err), 64'(0));
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) load(i, rnd_word());

      // Basic 4-word run, then held first word under backpressure.
      for (int i = 0; i < 4; i++) load(i, CW_WIDTH'(i + 1));
      run_seq(0, 3, 100, -1, 1'b0, 0);
      run_seq(0, 3, 100, -1, 1'b0, 3);

      load(62, rnd_word());
      load(63, rnd_word());
      load(0, rnd_word());
      run_seq(62, 0, 100, -1, 1'b0, 0);

      run_seq(0, 3, 100, 1, 1'b0, 0);
      run_seq(0, 3, 100, -1, 1'b0, 0);

      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_idle("idle_stop", 1'b0);

      // Writes and starts during RUN must not disturb the program.
      run_seq(0, 5, 70, -1, 1'b1, 0);
      run_seq(0, 5, 100, -1, 1'b0, 0);

      d = rnd_word();
      load_en = 1'b1;
      load_addr = ADDR_W'(7);
      load_data = d;
      start = 1'b1;
      start_addr = ADDR_W'(7);
      end_addr = ADDR_W'(7);
      step();
      load_en = 1'b0;
      start = 1'b0;
      mem_m[7] = d;
      chk_idle("start_load", 1'b0);
      run_seq(7, 7, 100, -1, 1'b0, 0);

      start_addr = ADDR_W'(10);
      end_addr = ADDR_W'(20);
      start = 1'b1;
      step();
      start = 1'b0;
      cw_ready = 1'b1;
      step();
      step();
      cw_ready = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_idle("mid_reset", 1'b0);
      chk("mid_reset_pc", 64'(pc), 64'(0));

      for (int r = 0; r < 12; r++) begin
         if ($urandom_range(1) == 1) load($urandom_range(DEPTH - 1), rnd_word());
         sa = $urandom_range(DEPTH - 1);
         ea = $urandom_range(DEPTH - 1);
         si = ($urandom_range(3) == 0) ? $urandom_range(5) : -1;
         run_seq(sa, ea, $urandom_range(100, 30), si, 1'b0, 0);
      end

`ifdef CW_PARITY_EN
      dut.mem[2] = dut.mem[2] ^ CW_WIDTH'(1);
      mem_m[2] = mem_m[2] ^ CW_WIDTH'(1);
      corrupt_addr = 2;
      run_seq(0, 3, 100, -1, 1'b0, 0);
      chk("parity_sticky", 64'(parity_err), 64'(1));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      perr_m = 1'b0;
      corrupt_addr = -1;
      chk("parity_reset", 64'(parity_err), 64'(0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
